mem_miss_handler: RTL and testbench

- Stage directly downstream of the L1 data cache. It accepts load misses and all stores from the cache, queues them in order, and services them against a fixed-latency backing data memory.
- Loads return data tagged with destination register and PC, plus a full-word refill for the cache. Stores are written through to the backing memory.
- Single outstanding memory access; up to QDEPTH requests buffered in front of it.

---
 rtl/mem_miss_handler.sv | 154 +++++++++++++++
 tb/tb_mem_miss_handler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_miss_handler.sv
// Miss/store handler behind the L1 D-cache: in-order request FIFO feeding a
// single fixed-latency backing-memory access; loads return data plus a refill word.
module mem_miss_handler #(
  parameter int QDEPTH  = 4,
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_optype,
  input  logic [31:0] req_addr,
  input  logic [5:0]  req_reg,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic        resp_is_store,
  output logic [5:0]  resp_reg,
  output logic [31:0] resp_pc,
  output logic [31:0] resp_data,
  output logic        fill_valid,
  output logic [31:0] fill_addr,
  output logic [31:0] fill_data,
  output logic        busy
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [3:0] OP_LB = 4'd7;
  localparam logic [3:0] OP_LW = 4'd8;
  localparam logic [3:0] OP_SB = 4'd9;
  localparam logic [3:0] OP_SW = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [CW-1:0] cnt;
  logic          op_legal, enq, pop, access;

  logic [3:0]  q_op   [QDEPTH];
  logic [31:0] q_addr [QDEPTH];
  logic [5:0]  q_reg  [QDEPTH];
  logic [31:0] q_pc   [QDEPTH];
  logic [31:0] q_data [QDEPTH];

  logic [3:0]  w_op;
  logic [31:0] w_addr, w_pc, w_data;
  logic [5:0]  w_reg;

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic              w_is_store;

  assign op_legal  = (req_optype == OP_LB) || (req_optype == OP_LW) ||
                     (req_optype == OP_SB) || (req_optype == OP_SW);
  // Ready comes from the registered count only, so a pop never frees a slot early.
  assign req_ready = (count < (PW+1)'(QDEPTH));
  assign enq       = req_valid && req_ready && op_legal;
  assign busy      = (count != '0) || (state != IDLE);
  assign resp_valid = (state == RESP);
  assign fill_valid = (state == RESP) && !resp_is_store;

  assign w_idx      = w_addr[ADDR_W+1:2];
  assign lane       = w_addr[1:0];
  assign rd_word    = mem[w_idx];
  assign rd_byte    = rd_word[{lane, 3'b000} +: 8];
  assign w_is_store = (w_op == OP_SB) || (w_op == OP_SW);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop       = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (cnt == '0) begin
        access    = 1'b1;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      cnt           <= '0;
      resp_is_store <= 1'b0;
      resp_reg      <= '0;
      resp_pc       <= '0;
      resp_data     <= '0;
      fill_addr     <= '0;
      fill_data     <= '0;
    end else begin
      state <= state_nxt;
      count <= count + (PW+1)'(enq) - (PW+1)'(pop);
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        cnt    <= CW'(MEM_LAT - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (access) begin
        resp_is_store <= w_is_store;
        resp_reg      <= w_reg;
        resp_pc       <= w_pc;
        fill_addr     <= {w_addr[31:2], 2'b00};
        fill_data     <= rd_word;
        if (w_is_store)         resp_data <= w_data;
        else if (w_op == OP_LB) resp_data <= {24'b0, rd_byte};
        else                    resp_data <= rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_op[wr_ptr]   <= req_optype;
      q_addr[wr_ptr] <= req_addr;
      q_reg[wr_ptr]  <= req_reg;
      q_pc[wr_ptr]   <= req_pc;
      q_data[wr_ptr] <= req_data;
    end
    if (pop) begin
      w_op   <= q_op[rd_ptr];
      w_addr <= q_addr[rd_ptr];
      w_reg  <= q_reg[rd_ptr];
      w_pc   <= q_pc[rd_ptr];
      w_data <= q_data[rd_ptr];
    end
  end

  // Backing memory is never reset; a store landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && access && w_is_store) begin
      if (w_op == OP_SW) mem[w_idx] <= w_data;
      else               mem[w_idx][{lane, 3'b000} +: 8] <= w_data[7:0];
    end
  end

endmodule

// File: tb/tb_mem_miss_handler.sv
// Directed bench for mem_miss_handler: responses are logged on the falling edge
// and compared against hand-computed values.
module tb_mem_miss_handler;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready;
  logic [3:0]  req_optype;
  logic [31:0] req_addr, req_pc, req_data;
  logic [5:0]  req_reg;
  logic        resp_valid, resp_is_store, fill_valid, busy;
  logic [5:0]  resp_reg;
  logic [31:0] resp_pc, resp_data, fill_addr, fill_data;

  always #5 clk = ~clk;

  mem_miss_handler #(.QDEPTH(4), .MEM_LAT(4), .ADDR_W(13)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_optype(req_optype),
    .req_addr(req_addr), .req_reg(req_reg), .req_pc(req_pc), .req_data(req_data),
    .resp_valid(resp_valid), .resp_is_store(resp_is_store), .resp_reg(resp_reg),
    .resp_pc(resp_pc), .resp_data(resp_data), .fill_valid(fill_valid),
    .fill_addr(fill_addr), .fill_data(fill_data), .busy(busy)
  );

  typedef struct {
    logic        st;
    logic [5:0]  rg;
    logic [31:0] pc, data, faddr, fdata;
    logic        fv;
    int          cyc;
  } rsp_t;

  rsp_t log_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc;
  bit   stalled;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_valid === 1'b1)
      log_q.push_back('{resp_is_store, resp_reg, resp_pc, resp_data,
                        fill_addr, fill_data, fill_valid, cyc});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [5:0] rg,
                      input logic [31:0] pc, input logic [31:0] data, output bit was_stalled);
    int n;
    req_valid  = 1'b1;
    req_optype = op;
    req_addr   = addr;
    req_reg    = rg;
    req_pc     = pc;
    req_data   = data;
    was_stalled = !req_ready;
    n = 0;
    while (!req_ready && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) check("send_ready_timeout", {31'b0, req_ready}, 32'd1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((busy !== 1'b0 || resp_valid !== 1'b0) && n < 300) begin
      tick;
      n++;
    end
    if (n >= 300) check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_optype = '0; req_addr = '0;
    req_reg = '0; req_pc = '0; req_data = '0;
    tick; tick;
    rst = 1'b0;

    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_fill_valid", {31'b0, fill_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_fill_addr", fill_addr, 32'd0);

    // Store then dependent load to the same word.
    log_q.delete();
    send(4'd10, 32'h40, 6'd1, 32'h1000, 32'hDEADBEEF, stalled);
    send(4'd8,  32'h40, 6'd5, 32'h1004, 32'h0, stalled);
    wait_idle;
    check("sl_count", log_q.size(), 32'd2);
    check("sl_st_is_store", {31'b0, log_q[0].st}, 32'd1);
    check("sl_st_fill_valid", {31'b0, log_q[0].fv}, 32'd0);
    check("sl_st_data", log_q[0].data, 32'hDEADBEEF);
    check("sl_ld_is_store", {31'b0, log_q[1].st}, 32'd0);
    check("sl_ld_data", log_q[1].data, 32'hDEADBEEF);
    check("sl_ld_reg", {26'b0, log_q[1].rg}, 32'd5);
    check("sl_ld_pc", log_q[1].pc, 32'h1004);
    check("sl_ld_fill_valid", {31'b0, log_q[1].fv}, 32'd1);
    check("sl_ld_fill_addr", log_q[1].faddr, 32'h40);
    check("sl_gap", log_q[1].cyc - log_q[0].cyc, 32'd6);

    // Single load into an idle handler.
    log_q.delete();
    send(4'd8, 32'h40, 6'd2, 32'h1100, 32'h0, stalled);
    acc = cyc;
    wait_idle;
    check("lat_count", log_q.size(), 32'd1);
    check("lat_cycles", log_q[0].cyc - acc, 32'd5);

    // Byte-lane write and read.
    log_q.delete();
    send(4'd10, 32'h100, 6'd3, 32'h1200, 32'h11223344, stalled);
    send(4'd9,  32'h102, 6'd4, 32'h1204, 32'h000000AA, stalled);
    send(4'd7,  32'h102, 6'd7, 32'h1208, 32'h0, stalled);
    send(4'd8,  32'h100, 6'd8, 32'h120C, 32'h0, stalled);
    wait_idle;
    check("bl_count", log_q.size(), 32'd4);
    check("bl_sb_echo", log_q[1].data, 32'h000000AA);
    check("bl_lb_data", log_q[2].data, 32'h000000AA);
    check("bl_lb_reg", {26'b0, log_q[2].rg}, 32'd7);
    check("bl_lb_fill_data", log_q[2].fdata, 32'h11AA3344);
    check("bl_lb_fill_addr", log_q[2].faddr, 32'h100);
    check("bl_lw_data", log_q[3].data, 32'h11AA3344);

    // Six back-to-back loads; the 6th must wait for a free slot.
    log_q.delete();
    for (int i = 0; i < 6; i++) begin
      send(4'd8, 32'h40, 6'(10 + i), 32'h2000 + 32'(4 * i), 32'h0, stalled);
      if (i == 4) check("bp_no_stall_4", {31'b0, stalled}, 32'd0);
      if (i == 5) check("bp_stall_5", {31'b0, stalled}, 32'd1);
    end
    wait_idle;
    check("bp_count", log_q.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_reg_%0d", i), {26'b0, log_q[i].rg}, 32'(10 + i));
      check($sformatf("bp_pc_%0d", i), log_q[i].pc, 32'h2000 + 32'(4 * i));
    end

    // Reset exactly on the in-flight store's write edge, with 3 queued.
    log_q.delete();
    send(4'd10, 32'h40, 6'd20, 32'h3000, 32'hBAD0BAD0, stalled);
    send(4'd10, 32'h44, 6'd21, 32'h3004, 32'h1, stalled);
    send(4'd10, 32'h48, 6'd22, 32'h3008, 32'h2, stalled);
    send(4'd10, 32'h4C, 6'd23, 32'h300C, 32'h3, stalled);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mr_req_ready", {31'b0, req_ready}, 32'd1);
    check("mr_busy", {31'b0, busy}, 32'd0);
    check("mr_resp_valid", {31'b0, resp_valid}, 32'd0);
    repeat (12) tick;
    check("mr_no_resp", log_q.size(), 32'd0);
    send(4'd8, 32'h40, 6'd9, 32'h3100, 32'h0, stalled);
    send(4'd8, 32'h100, 6'd9, 32'h3104, 32'h0, stalled);
    wait_idle;
    check("mr_rd_count", log_q.size(), 32'd2);
    check("mr_rd_40", log_q[0].data, 32'hDEADBEEF);
    check("mr_rd_100", log_q[1].data, 32'h11AA3344);

    // Illegal optype is dropped at accept.
    log_q.delete();
    send(4'd3, 32'h40, 6'd11, 32'h4000, 32'h5, stalled);
    check("ill_busy", {31'b0, busy}, 32'd0);
    repeat (10) tick;
    check("ill_no_resp", log_q.size(), 32'd0);
    check("ill_ready", {31'b0, req_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
